// File: rtl/exu_iter_if.sv
// Request/response bundle for the iterative execute unit.
// The master side presents operands and consumes results; the slave side is the unit.
interface exu_iter_if #(
  parameter int DATAWIDTH = 32,
  parameter int OPW       = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] src1;
  logic [DATAWIDTH-1:0] src2;
  logic [DATAWIDTH-1:0] imm;
  logic                 use_imm;
  logic [OPW-1:0]       op;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] result;
  logic                 busy;

  modport master (
    output in_valid, src1, src2, imm, use_imm, op, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, src1, src2, imm, use_imm, op, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/exu_iter.sv
// Multi-cycle execute unit: single-cycle ALU ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder.
// Valid/ready on both sides; a result is held in DONE until consumed.
module exu_iter #(
  parameter int DATAWIDTH = 32,
  parameter int OPW       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  exu_iter_if.slave   bus
);

  localparam int W    = DATAWIDTH;
  localparam int SHW  = $clog2(DATAWIDTH);
  localparam int CNTW = SHW + 1;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_CMPU  = OPW'(2);
  localparam logic [OPW-1:0] OP_CMPS  = OPW'(3);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(4);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(5);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(7);
  localparam logic [OPW-1:0] OP_AND   = OPW'(8);
  localparam logic [OPW-1:0] OP_OR    = OPW'(9);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(10);
  localparam logic [OPW-1:0] OP_MULHU = OPW'(11);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(12);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(13);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [CNTW-1:0]  cnt_q;
  logic [W-1:0]     hi_q;      // product high half / partial remainder
  logic [W-1:0]     lo_q;      // multiplier -> product low half / dividend -> quotient
  logic [W-1:0]     opnd_q;    // multiplicand / divisor
  logic [W-1:0]     result_q;

  // Encodes a compare outcome as 0 (equal), 2 (greater) or 4 (less).
  function automatic logic [W-1:0] cmp_code(input logic eq, input logic lt);
    if (eq)      return '0;
    else if (lt) return W'(4);
    else         return W'(2);
  endfunction

  // ---------------- request side ----------------
  logic              rdy, accept;
  logic [W-1:0]      a_in, b_in;
  logic signed [W-1:0] a_s, b_s;
  logic [W:0]        diff_ext;
  logic              eq, ltu, lts, ovf;
  logic [SHW-1:0]    shamt;
  logic              is_iter_in, is_div_in;
  logic [W-1:0]      simple_res;

  assign rdy    = !flush && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept = bus.in_valid && rdy;

  assign a_in  = bus.src1;
  assign b_in  = bus.use_imm ? bus.imm : bus.src2;
  assign a_s   = signed'(a_in);
  assign b_s   = signed'(b_in);
  assign shamt = b_in[SHW-1:0];

  // Borrow of the widened subtract gives the unsigned order; sign xor overflow the signed one.
  assign diff_ext = {1'b0, a_in} - {1'b0, b_in};
  assign eq       = (a_in == b_in);
  assign ltu      = diff_ext[W];
  assign ovf      = (a_s[W-1] ^ b_s[W-1]) & (diff_ext[W-1] ^ a_s[W-1]);
  assign lts      = diff_ext[W-1] ^ ovf;

  assign is_iter_in = (bus.op == OP_MUL) || (bus.op == OP_MULHU) ||
                      (bus.op == OP_DIVU) || (bus.op == OP_REMU);
  assign is_div_in  = (bus.op == OP_DIVU) || (bus.op == OP_REMU);

  // Single-cycle ALU result for the op being accepted.
  always_comb begin
    simple_res = '0;
    case (bus.op)
      OP_ADD:  simple_res = a_in + b_in;
      OP_SUB:  simple_res = diff_ext[W-1:0];
      OP_CMPU: simple_res = cmp_code(eq, ltu);
      OP_CMPS: simple_res = cmp_code(eq, lts);
      OP_SRL:  simple_res = a_in >> shamt;
      OP_SRA:  simple_res = a_s >>> shamt;
      OP_SLL:  simple_res = a_in << shamt;
      OP_XOR:  simple_res = a_in ^ b_in;
      OP_AND:  simple_res = a_in & b_in;
      OP_OR:   simple_res = a_in | b_in;
      default: simple_res = '0;
    endcase
  end

  // ---------------- iteration step ----------------
  logic         is_div_q;
  logic [W:0]   mul_sum;
  logic [W:0]   div_sh, div_df;
  logic         div_ge;
  logic [W-1:0] step_hi, step_lo, iter_res;

  assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_REMU);

  // Shift-add: add the multiplicand when the current multiplier bit is set, shift right.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});

  // Restoring divide: bring in the next dividend bit, subtract when it fits.
  // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
  assign div_sh = {hi_q, lo_q[W-1]};
  assign div_df = div_sh - {1'b0, opnd_q};
  assign div_ge = (div_sh >= {1'b0, opnd_q});

  // Next iteration registers and the result selected on the final step.
  always_comb begin
    step_hi  = mul_sum[W:1];
    step_lo  = {mul_sum[0], lo_q[W-1:1]};
    if (is_div_q) begin
      step_hi = div_ge ? div_df[W-1:0] : div_sh[W-1:0];
      step_lo = {lo_q[W-2:0], div_ge};
    end
    iter_res = '0;
    case (op_q)
      OP_MUL:   iter_res = step_lo;
      OP_MULHU: iter_res = step_hi;
      OP_DIVU:  iter_res = step_lo;
      OP_REMU:  iter_res = step_hi;
      default:  iter_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_iter_in ? BUSY : DONE;
      BUSY: if (cnt_q == CNTW'(1)) state_d = DONE;
      DONE: if (bus.out_ready) begin
              if (accept) state_d = is_iter_in ? BUSY : DONE;
              else        state_d = IDLE;
            end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Operand capture, iteration steps and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      cnt_q <= CNTW'(DATAWIDTH);
      if (is_iter_in) begin
        hi_q   <= '0;
        lo_q   <= is_div_in ? a_in : b_in;
        opnd_q <= is_div_in ? b_in : a_in;
      end else begin
        result_q <= simple_res;
      end
    end else if ((state_q == BUSY) && !flush) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) result_q <= iter_res;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_exu_iter.sv
// Bench for exu_iter: a 32-bit and an 8-bit instance driven with directed
// vectors, checked every cycle against a latency/arithmetic reference model.
module tb_exu_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;
  logic flush8;

  exu_iter_if #(.DATAWIDTH(32), .OPW(4)) bus  ();
  exu_iter_if #(.DATAWIDTH(8),  .OPW(4)) bus8 ();

  exu_iter #(.DATAWIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
  );

  exu_iter #(.DATAWIDTH(8), .OPW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(bus8.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic        pin_en  = 1'b0;
  logic [31:0] pin_val = '0;
  logic        pin8_en = 1'b0;
  logic [7:0]  pin8_val = '0;

  // Reference results straight from the operation definitions.
  function automatic logic [31:0] ref32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (a == b) ? 32'd0 : ((a > b) ? 32'd2 : 32'd4);
      4'd3:  return (a == b) ? 32'd0 : (($signed(a) > $signed(b)) ? 32'd2 : 32'd4);
      4'd4:  return a >> b[4:0];
      4'd5:  return 32'($signed(a) >>> b[4:0]);
      4'd6:  return a << b[4:0];
      4'd7:  return a ^ b;
      4'd8:  return a & b;
      4'd9:  return a | b;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [7:0] ref8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd10: return p[7:0];
      4'd11: return p[15:8];
      4'd12: return (b == 0) ? 8'hFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic is_long(input logic [3:0] op);
    return (op >= 4'd10) && (op <= 4'd13);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: one request in flight, result due a fixed number of cycles after accept.
  logic        m_in = 1'b0, m_long = 1'b0, m_pin_en = 1'b0;
  logic [31:0] m_res = '0, m_pin = '0;
  int          m_done = 0;

  always @(posedge clk or negedge rst_n) begin : model32
    logic v, r;
    if (!rst_n) begin
      m_in <= 1'b0; m_long <= 1'b0; m_pin_en <= 1'b0;
    end else begin
      v = m_in && (cyc >= m_done);
      r = !flush && (!m_in || (v && bus.out_ready));
      if (flush) m_in <= 1'b0;
      else if (bus.in_valid && r) begin
        m_in     <= 1'b1;
        m_res    <= ref32(bus.op, bus.src1, bus.use_imm ? bus.imm : bus.src2);
        m_long   <= is_long(bus.op);
        m_done   <= cyc + (is_long(bus.op) ? 33 : 1);
        m_pin_en <= pin_en;
        m_pin    <= pin_val;
      end else if (v && bus.out_ready) m_in <= 1'b0;
    end
  end

  logic       m8_in = 1'b0, m8_long = 1'b0, m8_pin_en = 1'b0;
  logic [7:0] m8_res = '0, m8_pin = '0;
  int         m8_done = 0;

  always @(posedge clk or negedge rst_n) begin : model8
    logic v, r;
    if (!rst_n) begin
      m8_in <= 1'b0; m8_long <= 1'b0; m8_pin_en <= 1'b0;
    end else begin
      v = m8_in && (cyc >= m8_done);
      r = !flush8 && (!m8_in || (v && bus8.out_ready));
      if (flush8) m8_in <= 1'b0;
      else if (bus8.in_valid && r) begin
        m8_in     <= 1'b1;
        m8_res    <= ref8(bus8.op, bus8.src1, bus8.use_imm ? bus8.imm : bus8.src2);
        m8_long   <= is_long(bus8.op);
        m8_done   <= cyc + (is_long(bus8.op) ? 9 : 1);
        m8_pin_en <= pin8_en;
        m8_pin    <= pin8_val;
      end else if (v && bus8.out_ready) m8_in <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: all DUT outputs against the model on every falling edge.
  always @(negedge clk) begin : compare
    logic ev, er, eb;
    if (!rst_n) begin
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst result",    bus.result,         32'd0);
      chk("rst busy",      32'(bus.busy),      32'd0);
      chk("rst8 out_valid", 32'(bus8.out_valid), 32'd0);
      chk("rst8 result",    32'(bus8.result),    32'd0);
    end else begin
      ev = m_in && (cyc >= m_done);
      er = !flush && (!m_in || (ev && bus.out_ready));
      eb = m_in && m_long && !ev;
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      chk("in_ready",  32'(bus.in_ready),  32'(er));
      chk("busy",      32'(bus.busy),      32'(eb));
      if (ev) chk("result", bus.result, m_res);
      if (ev && m_pin_en) chk("model pin", m_res, m_pin);

      ev = m8_in && (cyc >= m8_done);
      er = !flush8 && (!m8_in || (ev && bus8.out_ready));
      eb = m8_in && m8_long && !ev;
      chk("w8 out_valid", 32'(bus8.out_valid), 32'(ev));
      chk("w8 in_ready",  32'(bus8.in_ready),  32'(er));
      chk("w8 busy",      32'(bus8.busy),      32'(eb));
      if (ev) chk("w8 result", 32'(bus8.result), 32'(m8_res));
      if (ev && m8_pin_en) chk("w8 model pin", 32'(m8_res), 32'(m8_pin));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic ui, input logic [31:0] pin);
    bus.op = op; bus.src1 = a; bus.src2 = b; bus.imm = im; bus.use_imm = ui;
    bus.in_valid = 1'b1; pin_en = 1'b1; pin_val = pin;
    tick(1);
    bus.in_valid = 1'b0; pin_en = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] pin);
    bus8.op = op; bus8.src1 = a; bus8.src2 = b; bus8.imm = 8'd0; bus8.use_imm = 1'b0;
    bus8.in_valid = 1'b1; pin8_en = 1'b1; pin8_val = pin;
    tick(1);
    bus8.in_valid = 1'b0; pin8_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush8 = 1'b0;
    bus.in_valid = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.imm = '0;
    bus.use_imm = 1'b0; bus.op = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.src1 = '0; bus8.src2 = '0; bus8.imm = '0;
    bus8.use_imm = 1'b0; bus8.op = '0; bus8.out_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Back-to-back single-cycle ops
    issue(4'd0, 32'hFFFF_FFFF, 32'd1,          32'd0,  1'b0, 32'h0000_0000);
    issue(4'd1, 32'd5,         32'd7,          32'd0,  1'b0, 32'hFFFF_FFFE);
    issue(4'd5, 32'h8000_0000, 32'd4,          32'd0,  1'b0, 32'hF800_0000);
    issue(4'd6, 32'd1,         32'h1F,         32'h23, 1'b1, 32'h0000_0008);
    issue(4'd4, 32'h8000_0000, 32'h24,         32'd0,  1'b0, 32'h0800_0000);
    issue(4'd7, 32'hF0F0,      32'hFF00,       32'd0,  1'b0, 32'h0000_0FF0);
    issue(4'd8, 32'hF0F0,      32'hFF00,       32'd0,  1'b0, 32'h0000_F000);
    issue(4'd9, 32'hF0F0,      32'hFF00,       32'd0,  1'b0, 32'h0000_FFF0);
    issue(4'd2, 32'd1,         32'hFFFF_FFFF,  32'd0,  1'b0, 32'd4);
    issue(4'd3, 32'd1,         32'hFFFF_FFFF,  32'd0,  1'b0, 32'd2);
    issue(4'd2, 32'd5,         32'd5,          32'd0,  1'b0, 32'd0);
    issue(4'd3, 32'd5,         32'd5,          32'd0,  1'b0, 32'd0);
    issue(4'd14, 32'd9,        32'd9,          32'd0,  1'b0, 32'd0);
    issue(4'd15, 32'd9,        32'd9,          32'd0,  1'b0, 32'd0);
    tick(2);

    // Flush beats a simultaneous request
    flush = 1'b1;
    issue(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'd3);
    flush = 1'b0;
    tick(2);

    // Iterative multiply and divide
    issue(4'd10, 32'h1_0000,     32'h1_0000,     32'd0, 1'b0, 32'h0000_0000); tick(33);
    issue(4'd11, 32'h1_0000,     32'h1_0000,     32'd0, 1'b0, 32'h0000_0001); tick(33);
    issue(4'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 1'b0, 32'h0000_0001); tick(33);
    issue(4'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 1'b0, 32'hFFFF_FFFE); tick(33);
    issue(4'd12, 32'd100,        32'd7,          32'd0, 1'b0, 32'd14);        tick(33);
    issue(4'd13, 32'd100,        32'd7,          32'd0, 1'b0, 32'd2);         tick(33);
    issue(4'd12, 32'h1234_5678,  32'd0,          32'd0, 1'b0, 32'hFFFF_FFFF); tick(33);
    issue(4'd13, 32'd9,          32'd0,          32'd0, 1'b0, 32'd9);         tick(34);

    // Backpressure, then handshake plus new accept in one cycle
    bus.out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7);
    tick(5);
    bus.out_ready = 1'b1;
    issue(4'd7, 32'hA, 32'h5, 32'd0, 1'b0, 32'hF);
    tick(3);

    // Flush in the tenth BUSY cycle of a divide
    issue(4'd12, 32'd1000, 32'd3, 32'd0, 1'b0, 32'd333);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(40);
    issue(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 32'd30);
    tick(2);

    // Reset in the middle of a multiply on both instances
    bus8.op = 4'd10; bus8.src1 = 8'd3; bus8.src2 = 8'd5; bus8.in_valid = 1'b1;
    issue(4'd10, 32'd123, 32'd456, 32'd0, 1'b0, 32'd56088);
    bus8.in_valid = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 8-bit instance
    issue8(4'd10, 8'd15,  8'd17, 8'hFF); tick(10);
    issue8(4'd12, 8'd200, 8'd13, 8'd15); tick(10);
    issue8(4'd13, 8'd200, 8'd13, 8'd5);  tick(10);
    issue8(4'd0,  8'd250, 8'd10, 8'd4);  tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_iter.md
Name: exu_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute unit.
- Performs the same ALU operation set, generalised to DATAWIDTH bits, and adds iterative multiply and unsigned divide/remainder.
- Sits between decode/register read and writeback.
- Uses a valid/ready handshake on both sides, so the pipeline can stall on long operations.

Parameters:
- DATAWIDTH, 32, operand/result width; power of 2, >= 8.
- OPW, 4, width of op field.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the operation in flight.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  unit can accept a request this cycle.
- src1  input  DATAWIDTH  operand a (GPR rdata1).
- src2  input  DATAWIDTH  GPR rdata2.
- imm  input  DATAWIDTH  immediate.
- use_imm  input  1  1: b = imm, 0: b = src2.
- op  input  OPW  operation code, listed below.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  DATAWIDTH  result data.
- busy  output  1  high in BUSY state.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state = IDLE, out_valid = 0, result = 0, busy = 0; all internal registers cleared.
- Operand capture: a, b, op latched on the accept cycle (in_valid && in_ready). Inputs are ignored at all other times.
- Op codes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 CMPU: unsigned compare.
  - 3 CMPS: signed compare.
  - 4 SRL: logical shift right.
  - 5 SRA: arithmetic shift right.
  - 6 SLL: shift left.
  - 7 XOR, 8 AND, 9 OR.
  - 10 MUL: low DATAWIDTH bits of the product.
  - 11 MULHU: high DATAWIDTH bits of the unsigned product.
  - 12 DIVU, 13 REMU.
  - 14, 15: result 0, single-cycle.
- Compare encoding: result 0 if a==b, 2 if a>b, 4 if a<b. CMPS uses the sign xor overflow of a-b; CMPU uses the borrow.
- Shift amount: b[$clog2(DATAWIDTH)-1:0]; upper bits of b are ignored. ADD/SUB wrap modulo 2^DATAWIDTH.
- State machine IDLE/BUSY/DONE:
  - IDLE: in_ready = 1. On accept, ops 0-9 and 14-15 compute and register result, then go to DONE. Ops 10-13 load the iteration counter with DATAWIDTH and go to BUSY.
  - BUSY: in_ready = 0. One shift-add (multiply) or restoring-subtract (divide) step per cycle; counter decrements. When the counter reaches 0, result is registered and the state goes to DONE.
  - DONE: out_valid = 1, result held stable until out_ready. On out_ready: if in_valid, the new request is accepted in the same cycle (in_ready = out_ready in DONE), otherwise go to IDLE.
- Latency from accept cycle to out_valid:
  - Simple ops: 1 cycle.
  - MUL/MULHU/DIVU/REMU: DATAWIDTH+1 cycles.
  - Fixed latency, independent of operand values.
- Divide by zero: DIVU returns all ones; REMU returns a. Full latency still applies.
- Back-to-back simple ops with out_ready held high: one result per cycle.
- flush: in any state, next cycle is IDLE, out_valid = 0, no result delivered. Flush has priority over a simultaneous accept; in_ready = 0 while flush is high.
- Asynchronous reset mid-operation: immediate return to reset values; a partial result is never presented.
- out_valid falls only after a handshake, a flush, or a reset.

Test Plan:
- Simple ALU, DATAWIDTH=32, out_ready=1:
  - ADD 0xFFFFFFFF+1 -> 0.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLL with use_imm, imm=0x23 -> shift by 3.
  - Each result out_valid exactly 1 cycle after accept.
- Compare: CMPU 1 vs 0xFFFFFFFF -> 4; CMPS 1 vs 0xFFFFFFFF -> 2; equal operands -> 0 for both.
- Multiply: MUL 0x10000 x 0x10000 -> 0; MULHU same operands -> 1. out_valid at cycle 33 after accept; in_ready low throughout BUSY.
- Divide:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
  - Latency 33 cycles in every case.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> result and out_valid stable, in_ready=0. Then assert out_ready with in_valid high -> handshake and new accept in the same cycle.
- Abort: flush at BUSY cycle 10 of a DIVU -> no out_valid, in_ready=1 the next cycle. Repeat with rst_n low mid-MUL -> all outputs 0 immediately. Rerun with DATAWIDTH=8: MUL 15x17 -> 0xFF, latency 9.
